// File: rtl/mole_round_ctrl.sv
// -----------------------------------------------------------------------------
// mole_round_ctrl
//   Game-round sequencer for the Whack-a-Mole core. Runs ROUNDS rounds per game.
//   Each round waits GAP_TICKS cycles with no mole lit. It then lights a
//   pseudo-random mole, never the same position twice in a row, for up to
//   MOLE_TICKS cycles. The player's response is classified as a hit or a miss.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : start/restart request (honoured only in IDLE or DONE)
//   button_in  : debounced buttons, active-low (bit i low = button i pressed)
//   mole       : one-hot mole position, 4'b0000 when no mole is shown
//   score      : hit count, saturating at 255
//   miss_cnt   : miss count (wrong press or timeout), saturating at 255
//   round_cnt  : rounds completed in the current game
//   busy       : game in progress (GAP or SHOW)
//   done       : game finished, held until the next start
//   hit_pulse  : one-cycle strobe on a hit
//   miss_pulse : one-cycle strobe on a miss
// -----------------------------------------------------------------------------
module mole_round_ctrl #(
    parameter logic [31:0] GAP_TICKS  = 32'd10,
    parameter logic [31:0] MOLE_TICKS = 32'd25000000,
    parameter logic [7:0]  ROUNDS     = 8'd20,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] button_in,
    output logic [3:0] mole,
    output logic [7:0] score,
    output logic [7:0] miss_cnt,
    output logic [7:0] round_cnt,
    output logic       busy,
    output logic       done,
    output logic       hit_pulse,
    output logic       miss_pulse
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_SHOW = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q,      state_d;
    logic [3:0]  mole_q,       mole_d;
    logic [7:0]  score_q,      score_d;
    logic [7:0]  miss_cnt_q,   miss_cnt_d;
    logic [7:0]  round_cnt_q,  round_cnt_d;
    logic        busy_q,       busy_d;
    logic        done_q,       done_d;
    logic        hit_pulse_q,  hit_pulse_d;
    logic        miss_pulse_q, miss_pulse_d;
    logic [7:0]  lfsr_q,       lfsr_d;
    logic [1:0]  prev_pos_q,   prev_pos_d;
    logic [31:0] timer_q,      timer_d;
    logic [3:0]  btn_q,        btn_d;

    logic [3:0]  press;
    logic [1:0]  pick;
    logic [7:0]  round_next;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        // Falling edge of an active-low button; a held button fires only once.
        press = btn_q & ~button_in;

        // Skip the previous position so the same mole never appears twice in a row.
        pick = lfsr_q[1:0];
        if (pick == prev_pos_q) begin
            pick = prev_pos_q + 2'd1;
        end

        round_next = round_cnt_q + 8'd1;

        state_d      = state_q;
        mole_d       = mole_q;
        score_d      = score_q;
        miss_cnt_d   = miss_cnt_q;
        round_cnt_d  = round_cnt_q;
        busy_d       = busy_q;
        done_d       = done_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        prev_pos_d   = prev_pos_q;
        timer_d      = timer_q;
        btn_d        = button_in;
        // Fibonacci LFSR, taps 8,6,5,4; free-running in every state.
        lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_GAP;
                    mole_d      = 4'b0000;
                    score_d     = 8'd0;
                    miss_cnt_d  = 8'd0;
                    round_cnt_d = 8'd0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    timer_d     = GAP_TICKS - 32'd1;
                end
            end
            S_GAP: begin
                // Presses are deliberately ignored here.
                if (timer_q == 32'd0) begin
                    state_d    = S_SHOW;
                    mole_d     = 4'b0001 << pick;
                    prev_pos_d = pick;
                    timer_d    = MOLE_TICKS - 32'd1;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_SHOW: begin
                // A press wins over a timeout landing on the same cycle.
                if ((press != 4'b0000) || (timer_q == 32'd0)) begin
                    mole_d      = 4'b0000;
                    round_cnt_d = round_next;
                    // mole_q is one-hot, so equality also means exactly one button.
                    if ((press != 4'b0000) && (press == mole_q)) begin
                        hit_pulse_d = 1'b1;
                        score_d     = sat_inc(score_q);
                    end else begin
                        miss_pulse_d = 1'b1;
                        miss_cnt_d   = sat_inc(miss_cnt_q);
                    end
                    if (round_next == ROUNDS) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        timer_d = GAP_TICKS - 32'd1;
                    end
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                mole_d  = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mole_q       <= 4'b0000;
            score_q      <= 8'd0;
            miss_cnt_q   <= 8'd0;
            round_cnt_q  <= 8'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            lfsr_q       <= LFSR_SEED;
            prev_pos_q   <= 2'd0;
            timer_q      <= 32'd0;
            btn_q        <= 4'b1111;
        end else begin
            state_q      <= state_d;
            mole_q       <= mole_d;
            score_q      <= score_d;
            miss_cnt_q   <= miss_cnt_d;
            round_cnt_q  <= round_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            lfsr_q       <= lfsr_d;
            prev_pos_q   <= prev_pos_d;
            timer_q      <= timer_d;
            btn_q        <= btn_d;
        end
    end

    assign mole       = mole_q;
    assign score      = score_q;
    assign miss_cnt   = miss_cnt_q;
    assign round_cnt  = round_cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mole_round_ctrl
//   Directed bench for mole_round_ctrl with GAP_TICKS=4, MOLE_TICKS=8,
//   ROUNDS=3. Round vectors live in a table; reset, async reset and the
//   long non-repeat run are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mole_round_ctrl;

    localparam logic [31:0] GAP  = 32'd4;
    localparam logic [31:0] SHOW = 32'd8;
    localparam logic [7:0]  RND  = 8'd3;
    localparam logic [7:0]  SEED = 8'hA5;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] button_in;
    logic [3:0] mole;
    logic [7:0] score;
    logic [7:0] miss_cnt;
    logic [7:0] round_cnt;
    logic       busy;
    logic       done;
    logic       hit_pulse;
    logic       miss_pulse;

    mole_round_ctrl #(
        .GAP_TICKS (GAP),
        .MOLE_TICKS(SHOW),
        .ROUNDS    (RND),
        .LFSR_SEED (SEED)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .button_in (button_in),
        .mole      (mole),
        .score     (score),
        .miss_cnt  (miss_cnt),
        .round_cnt (round_cnt),
        .busy      (busy),
        .done      (done),
        .hit_pulse (hit_pulse),
        .miss_pulse(miss_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // act: 0 timeout, 1 press mole, 2 press wrong button, 3 press mole plus
    // another, 4 press everything in the last GAP cycle and hold through SHOW.
    typedef struct {
        int         act;
        int         dly;
        bit         start_mid;
        logic       e_hit;
        logic [7:0] e_score;
        logic [7:0] e_miss;
        logic [7:0] e_round;
        logic       e_done;
    } vec_t;

    vec_t       vecs[6];
    int         checks;
    int         errors;
    logic [3:0] prev_mole;
    logic [7:0] lfsr_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Entered on the negedge where the GAP phase has just begun.
    task automatic do_round(input vec_t v);
        int         gap_n;
        int         n;
        logic [3:0] cur;
        logic [3:0] other;
        gap_n = 0;
        while ((mole == 4'b0000) && (gap_n < 20)) begin
            @(negedge clk);
            gap_n++;
            if (gap_n == 1) begin
                chk("pulse_one_cycle", {30'd0, hit_pulse, miss_pulse}, 32'd0);
            end
            if ((gap_n == 3) && (v.act == 4)) begin
                button_in = 4'b0000;
            end
        end
        chk("gap_len", gap_n, GAP);
        cur = mole;
        chk("mole_onehot", {31'd0, $onehot(cur)}, 32'd1);
        chk("mole_nonrepeat", {31'd0, (cur == prev_mole)}, 32'd0);
        prev_mole = cur;
        other = {cur[2:0], cur[3]};
        n = 0;
        if (v.act == 1 || v.act == 2 || v.act == 3) begin
            if (v.start_mid) start = 1'b1;
            for (int i = 0; i < v.dly; i++) begin
                @(negedge clk);
                n++;
                start = 1'b0;
            end
            case (v.act)
                1:       button_in = ~cur;
                2:       button_in = ~other;
                default: button_in = ~(cur | other);
            endcase
        end
        while (!(hit_pulse || miss_pulse) && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        button_in = 4'b1111;
        chk("resolve_latency", n, (v.act == 0 || v.act == 4) ? SHOW : v.dly + 1);
        chk("mole_cleared", {28'd0, mole}, 32'd0);
        chk("hit_pulse", {31'd0, hit_pulse}, {31'd0, v.e_hit});
        chk("miss_pulse", {31'd0, miss_pulse}, {31'd0, ~v.e_hit});
        chk("score", {24'd0, score}, {24'd0, v.e_score});
        chk("miss_cnt", {24'd0, miss_cnt}, {24'd0, v.e_miss});
        chk("round_cnt", {24'd0, round_cnt}, {24'd0, v.e_round});
        chk("done", {31'd0, done}, {31'd0, v.e_done});
        chk("busy", {31'd0, busy}, {31'd0, ~v.e_done});
    endtask

    // Issue start from IDLE/DONE and check the counters were cleared.
    task automatic start_game();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_done_clr", {31'd0, done}, 32'd0);
        chk("start_clr_cnt", {score, miss_cnt, round_cnt, 8'd0}, 32'd0);
    endtask

    task automatic check_done_hold(input logic [7:0] s, input logic [7:0] m);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("done_hold", {29'd0, done, busy, (hit_pulse | miss_pulse)}, 32'd4);
            chk("done_cnt_hold", {8'd0, score, miss_cnt, round_cnt}, {8'd0, s, m, RND});
            chk("done_mole", {28'd0, mole}, 32'd0);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        button_in = 4'b1111;
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        prev_mole = 4'b0001;
        lfsr_m    = SEED;
    endtask

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;
        // Game A: hit at SHOW cycle 2, timeout, wrong press.
        vecs[0] = '{act: 1, dly: 2, start_mid: 1'b0, e_hit: 1'b1, e_score: 8'd1, e_miss: 8'd0, e_round: 8'd1, e_done: 1'b0};
        vecs[1] = '{act: 0, dly: 0, start_mid: 1'b0, e_hit: 1'b0, e_score: 8'd1, e_miss: 8'd1, e_round: 8'd2, e_done: 1'b0};
        vecs[2] = '{act: 2, dly: 3, start_mid: 1'b0, e_hit: 1'b0, e_score: 8'd1, e_miss: 8'd2, e_round: 8'd3, e_done: 1'b1};
        // Game B: mash with start mid-round, press on the timer==0 cycle, GAP press held.
        vecs[3] = '{act: 3, dly: 1, start_mid: 1'b1, e_hit: 1'b0, e_score: 8'd0, e_miss: 8'd1, e_round: 8'd1, e_done: 1'b0};
        vecs[4] = '{act: 1, dly: 7, start_mid: 1'b0, e_hit: 1'b1, e_score: 8'd1, e_miss: 8'd1, e_round: 8'd2, e_done: 1'b0};
        vecs[5] = '{act: 4, dly: 0, start_mid: 1'b0, e_hit: 1'b0, e_score: 8'd1, e_miss: 8'd2, e_round: 8'd3, e_done: 1'b1};

        // Reset and idle with a free-running LFSR.
        do_reset();
        #1;
        chk("rst_lfsr", {24'd0, dut.lfsr_q}, {24'd0, SEED});
        chk("rst_outputs", {mole, score, miss_cnt, round_cnt, busy, done, hit_pulse, miss_pulse}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lfsr_m = lfsr_step(lfsr_m);
            chk("idle_lfsr", {24'd0, dut.lfsr_q}, {24'd0, lfsr_m});
            chk("idle_outputs", {mole, score, miss_cnt, round_cnt, busy, done, hit_pulse, miss_pulse}, 32'd0);
        end

        // Two table-driven games.
        for (int g = 0; g < 2; g++) begin
            start_game();
            for (int r = 0; r < 3; r++) begin
                do_round(vecs[g * 3 + r]);
            end
            check_done_hold(vecs[g * 3 + 2].e_score, vecs[g * 3 + 2].e_miss);
        end

        // Async reset in the middle of SHOW, with a nonzero score.
        start_game();
        v = '{act: 1, dly: 0, start_mid: 1'b0, e_hit: 1'b1, e_score: 8'd1, e_miss: 8'd0, e_round: 8'd1, e_done: 1'b0};
        do_round(v);
        for (int i = 0; i < 20 && mole == 4'b0000; i++) @(negedge clk);
        chk("pre_reset_mole", {31'd0, (mole != 4'b0000)}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mole", {28'd0, mole}, 32'd0);
        chk("async_rst_cnt", {8'd0, score, miss_cnt, round_cnt}, 32'd0);
        chk("async_rst_flags", {30'd0, busy, done}, 32'd0);
        chk("async_rst_state", {30'd0, dut.state_q}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        prev_mole = 4'b0001;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {30'd0, busy, done}, 32'd0);

        // 51 timed-out rounds: no mole position ever repeats back to back.
        for (int g = 0; g < 17; g++) begin
            start_game();
            for (int r = 0; r < 3; r++) begin
                v = '{act: 0, dly: 0, start_mid: 1'b0, e_hit: 1'b0, e_score: 8'd0,
                      e_miss: 8'(r + 1), e_round: 8'(r + 1), e_done: (r == 2)};
                do_round(v);
            end
            @(negedge clk);
            chk("bulk_done", {30'd0, done, busy}, 32'd2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
